// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources,
// with locked bursts, an inter-frame gap in s_ticks and a done-tick timeout.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int IDW       = 2,
   parameter int DBIT      = 8,
   parameter int GAP_TICK  = 16,
   parameter int BURST_MAX = 4,
   parameter int TO_TICK   = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_tick,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      lock,
   input  logic [NREQ*DBIT-1:0] req_data,
   output logic [NREQ-1:0]      grant,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_din,
   input  logic                 tx_done_tick,
   output logic                 busy,
   output logic [IDW-1:0]       cur_id,
   output logic                 err_timeout
);

   // Handshake: a requester holds req with stable data until it sees its grant
   // pulse; the byte is taken in that cycle and req/data may change afterwards.
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_DONE, ST_GAP} state_t;

   localparam int BW = $clog2(BURST_MAX) + 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
   localparam logic [15:0]   TO_LAST    = 16'(TO_TICK - 1);
   localparam logic [15:0]   GAP_LAST   = 16'(GAP_TICK - 1);

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    cur_id_q, cur_id_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [15:0]       to_cnt_q, to_cnt_d;
   logic [15:0]       gap_cnt_q, gap_cnt_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              tx_start_q, tx_start_d;
   logic [DBIT-1:0]   tx_din_q, tx_din_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [DBIT-1:0]   data_arr [NREQ];
   logic [IDW-1:0]    cand;
   logic [IDW-1:0]    sel;
   logic              found;

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < NREQ; i++) data_arr[i] = req_data[i*DBIT +: DBIT];
   end

   // Search starts just past the last owner so every requester gets a turn.
   always_comb begin
      cand  = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = wrap_idx(ptr_q, k);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_id_d   = cur_id_q;
      burst_d    = burst_q;
      to_cnt_d   = to_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      grant_d    = '0;
      tx_start_d = 1'b0;
      tx_din_d   = tx_din_q;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d       = ST_LOAD;
               tx_din_d      = data_arr[sel];
               cur_id_d      = sel;
               ptr_d         = sel;
               burst_d       = '0;
               grant_d[sel]  = 1'b1;
               tx_start_d    = 1'b1;
            end
         end
         ST_LOAD: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_done_tick) begin
               if (lock[cur_id_q] && req[cur_id_q] && (burst_q < BURST_LAST)) begin
                  state_d           = ST_LOAD;
                  tx_din_d          = data_arr[cur_id_q];
                  burst_d           = burst_q + 1'b1;
                  grant_d[cur_id_q] = 1'b1;
                  tx_start_d        = 1'b1;
               end else if (GAP_TICK == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end
            end else if (s_tick) begin
               // A done tick in the expiry cycle is taken above, so no error then.
               if (to_cnt_q == TO_LAST) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  to_cnt_d = to_cnt_q + 16'd1;
               end
            end
         end
         ST_GAP: begin
            if (s_tick) begin
               if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
               else gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= IDW'(NREQ - 1);
         cur_id_q   <= '0;
         burst_q    <= '0;
         to_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         grant_q    <= '0;
         tx_start_q <= 1'b0;
         tx_din_q   <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_id_q   <= cur_id_d;
         burst_q    <= burst_d;
         to_cnt_q   <= to_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         grant_q    <= grant_d;
         tx_start_q <= tx_start_d;
         tx_din_q   <= tx_din_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign grant       = grant_q;
   assign tx_start    = tx_start_q;
   assign tx_din      = tx_din_q;
   assign busy        = busy_q;
   assign cur_id      = cur_id_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a transmitter
// model, a scoreboard of expected {id,byte} grants, and a GAP_TICK=0 instance.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int DBIT    = 8;
   localparam int TO_TICK = 4096;
   localparam int W       = IDW + DBIT;

   logic              clk, reset, s_tick;
   logic [NREQ-1:0]   req, lock, grant;
   logic [NREQ*DBIT-1:0] req_data;
   logic              tx_start, tx_done_tick, busy, err_timeout;
   logic [DBIT-1:0]   tx_din;
   logic [IDW-1:0]    cur_id;

   logic [NREQ-1:0]   req2, grant2;
   logic [NREQ*DBIT-1:0] data2;
   logic              tx_start2, done2, busy2, err2;
   logic [DBIT-1:0]   tx_din2;
   logic [IDW-1:0]    cur_id2;

   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .GAP_TICK(16),
                     .BURST_MAX(4), .TO_TICK(TO_TICK)) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .req(req), .lock(lock),
      .req_data(req_data), .grant(grant), .tx_start(tx_start), .tx_din(tx_din),
      .tx_done_tick(tx_done_tick), .busy(busy), .cur_id(cur_id),
      .err_timeout(err_timeout));

   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .GAP_TICK(0),
                     .BURST_MAX(4), .TO_TICK(TO_TICK)) dut_g0 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .req(req2), .lock('0),
      .req_data(data2), .grant(grant2), .tx_start(tx_start2), .tx_din(tx_din2),
      .tx_done_tick(done2), .busy(busy2), .cur_id(cur_id2),
      .err_timeout(err2));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- bench state ----------------
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int err_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0]   src_q[NREQ][$];
   logic [NREQ-1:0] lock_en, req2_en;
   int  tx_mode;
   int  s_div, wait_cnt, tick_cnt, wait2;
   bit  pending, pending2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_src(input int id, input logic [7:0] b);
      src_q[id].push_back(b);
   endtask

   task automatic push_exp(input int id, input logic [7:0] b);
      exp_q.push_back({IDW'(id), b});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      lock_en = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!tx_start && n < 200) begin @(negedge clk); n++; end
      chk(tag, tx_start, 1);
   endtask

   task automatic drain(input string tag, input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < limit) begin @(negedge clk); n++; end
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   // Single stimulus process: s_tick divider, transmitter models, requesters.
   always @(posedge clk) begin
      #1;
      cyc++;
      s_div  = (s_div == 2) ? 0 : s_div + 1;
      s_tick = (s_div == 0);
      tx_done_tick = 1'b0;
      done2 = 1'b0;
      if (!busy) pending = 1'b0;
      if (tx_start) begin
         pending  = 1'b1;
         wait_cnt = $urandom_range(2, 10);
         tick_cnt = 0;
      end else if (pending) begin
         if (tx_mode == 0) begin
            if (wait_cnt == 0) begin tx_done_tick = 1'b1; pending = 1'b0; end
            else wait_cnt--;
         end else if (tx_mode == 2 && s_tick) begin
            tick_cnt++;
            if (tick_cnt == TO_TICK) begin tx_done_tick = 1'b1; pending = 1'b0; end
         end
      end
      if (!busy2) pending2 = 1'b0;
      if (tx_start2) begin
         pending2 = 1'b1;
         wait2    = $urandom_range(2, 10);
      end else if (pending2) begin
         if (wait2 == 0) begin done2 = 1'b1; pending2 = 1'b0; end
         else wait2--;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         req[i] = (src_q[i].size() > 0);
         req_data[i*DBIT +: DBIT] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
         lock[i] = lock_en[i];
      end
      req2 = req2_en;
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (err_timeout) err_cnt++;
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            chk("sb_extra_start", tx_start, 0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("sb_id", cur_id, e[W-1:DBIT]);
            chk("sb_data", tx_din, e[DBIT-1:0]);
            chk("sb_grant", grant, 32'(1) << e[W-1:DBIT]);
            chk("sb_busy", busy, 1);
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int n, cnt, e0, done_cyc;
      logic [7:0] b;
      reset = 1'b0; s_tick = 1'b0; tx_done_tick = 1'b0; done2 = 1'b0;
      req = '0; lock = '0; req_data = '0; req2 = '0; lock_en = '0; req2_en = '0;
      data2 = 32'h44332211;
      tx_mode = 0; s_div = 0; pending = 0; pending2 = 0;
      wait_cnt = 0; tick_cnt = 0; wait2 = 0; done_cyc = 0;

      do_reset();
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_din", tx_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_id", cur_id, 0);
      chk("rst_err", err_timeout, 0);

      // single requester, latency and gap length
      push_src(2, 8'hA5); push_exp(2, 8'hA5);
      n = 0;
      do begin @(negedge clk); n++; end while (!tx_start && n < 20);
      chk("t1_latency", n, 2);
      n = 0;
      while (!tx_done_tick && n < 200) begin @(negedge clk); n++; end
      chk("t1_done", tx_done_tick, 1);
      @(negedge clk);
      cnt = 0; n = 0;
      while (busy && n < 500) begin
         if (s_tick) cnt++;
         @(negedge clk); n++;
      end
      chk("t1_gap_ticks", cnt, 16);
      chk("t1_idle", busy, 0);

      // round-robin 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         push_src(i % NREQ, b); push_exp(i % NREQ, b);
      end
      drain("rr", 2000);

      // locked burst of requester 1 interrupted by requester 0
      do_reset();
      lock_en = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         b = 8'(8'h10 + i);
         push_src(1, b);
         push_exp(1, b);
         if (i == 3) push_exp(0, 8'hC3);
      end
      wait_start("burst_first");
      push_src(0, 8'hC3);
      drain("burst", 4000);

      // timeout: transmitter never answers
      do_reset();
      tx_mode = 1;
      e0 = err_cnt;
      push_src(2, 8'h77); push_exp(2, 8'h77);
      wait_start("to_start");
      @(negedge clk);
      cnt = 0; n = 0;
      while (!err_timeout && n < 20000) begin
         if (s_tick) cnt++;
         @(negedge clk); n++;
      end
      chk("to_pulse", err_timeout, 1);
      chk("to_ticks", cnt, TO_TICK);
      chk("to_busy", busy, 0);
      @(negedge clk);
      chk("to_once", err_timeout, 0);
      chk("to_count", err_cnt - e0, 1);

      // done tick in the same cycle as expiry: no error
      tx_mode = 2;
      e0 = err_cnt;
      push_src(3, 8'h3C); push_exp(3, 8'h3C);
      drain("sim", 20000);
      chk("sim_no_err", err_cnt - e0, 0);

      // reset in the middle of a frame
      tx_mode = 1;
      push_src(3, 8'h5A); push_exp(3, 8'h5A);
      wait_start("mid_start");
      repeat (5) @(negedge clk);
      chk("mid_busy", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_grant", grant, 0);
      chk("mid_start0", tx_start, 0);
      chk("mid_din", tx_din, 0);
      chk("mid_busy0", busy, 0);
      chk("mid_id", cur_id, 0);
      chk("mid_err", err_timeout, 0);
      reset = 1'b1;
      tx_mode = 0;
      push_src(0, 8'h01); push_src(1, 8'h02);
      push_exp(0, 8'h01); push_exp(1, 8'h02);
      drain("post_rst", 2000);

      // GAP_TICK=0 instance: next start two clocks after each done
      req2_en = 4'b0011;
      for (int f = 0; f < 4; f++) begin
         n = 0;
         while (!tx_start2 && n < 200) begin @(negedge clk); n++; end
         chk("g0_start", tx_start2, 1);
         chk("g0_id", cur_id2, f % 2);
         chk("g0_data", tx_din2, (f % 2 == 0) ? 8'h11 : 8'h22);
         chk("g0_grant", grant2, (f % 2 == 0) ? 4'b0001 : 4'b0010);
         if (f > 0) chk("g0_latency", cyc - done_cyc, 2);
         @(negedge clk);
         n = 0;
         while (!done2 && n < 200) begin @(negedge clk); n++; end
         chk("g0_done", done2, 1);
         done_cyc = cyc;
      end
      req2_en = '0;
      n = 0;
      while (busy2 && n < 200) begin @(negedge clk); n++; end
      chk("g0_idle", busy2, 0);
      chk("g0_no_err", err2, 0);

      repeat (5) @(negedge clk);
      chk("final_sb_left", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
